// File: rtl/apb_regfile_slave.sv
// APB3 register-file slave: GP read/write bank, live status word and a sticky
// interrupt source/mask pair with a registered level interrupt output.
// Each transfer passes through IDLE -> (WAIT) -> RESP. Writes commit and read data
// is loaded on the same edge that raises pready.
module apb_regfile_slave #(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned INTR_W      = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [ADDR_W-1:0]          paddr,
   input  logic                       psel,
   input  logic                       penable,
   input  logic                       pwrite,
   input  logic [DATA_W-1:0]          pwdata,
   input  logic [DATA_W/8-1:0]        pstrb,
   output logic [DATA_W-1:0]          prdata,
   output logic                       pready,
   output logic                       pslverr,
   input  logic [INTR_W-1:0]          hw_intr_i,
   input  logic [DATA_W-1:0]          hw_status_i,
   output logic [NUM_REGS*DATA_W-1:0] gp_regs_o,
   output logic                       intr_o
);

   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // Transfer FSM and wait-state counter
   logic [1:0]              state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;

   // Registered APB response and interrupt output
   logic                    pready_q, pready_d;
   logic                    pslverr_q, pslverr_d;
   logic [DATA_W-1:0]       prdata_q, prdata_d;
   logic                    intr_q, intr_d;

   // Register storage
   logic [INTR_W-1:0]       src_q, src_d;
   logic [INTR_W-1:0]       msk_q, msk_d;
   logic [DATA_W-1:0]       gp_q [NUM_REGS];
   logic [DATA_W-1:0]       gp_d [NUM_REGS];

   // Address decode and datapath helpers
   logic                    sel_src, sel_msk, sel_stat;
   logic [NUM_REGS-1:0]     sel_gp;
   logic                    addr_err;
   logic [DATA_W-1:0]       wmask;
   logic [DATA_W-1:0]       rd_val;
   logic                    commit;
   logic                    wr_ok;

   // Decode the current bus address; full-address compares reject misaligned offsets
   always_comb begin
      sel_src  = (paddr == ADDR_W'(0));
      sel_msk  = (paddr == ADDR_W'(4));
      sel_stat = (paddr == ADDR_W'(8));
      for (int i = 0; i < NUM_REGS; i++) begin
         sel_gp[i] = (paddr == ADDR_W'(16 + 4 * i));
      end
      addr_err = ~(sel_src | sel_msk | sel_stat | (|sel_gp))
               | (paddr[1:0] != 2'b00)
               | (pwrite & sel_stat);
      for (int b = 0; b < STRB_W; b++) begin
         wmask[8*b +: 8] = {8{pstrb[b]}};
      end
   end

   // Read mux over the register map; unmapped locations read as zero
   always_comb begin
      rd_val = '0;
      if (sel_src) begin
         rd_val[INTR_W-1:0] = src_q;
      end
      if (sel_msk) begin
         rd_val[INTR_W-1:0] = msk_q;
      end
      if (sel_stat) begin
         rd_val = hw_status_i;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         if (sel_gp[i]) begin
            rd_val = gp_q[i];
         end
      end
   end

   // Transfer FSM: commit is the single-cycle strobe for the edge entering RESP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (psel && penable) begin
               if (WAIT_STATES == 0) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'd1;
               end
            end
         end
         ST_WAIT: begin
            if (!psel) begin
               // Master abandoned the transfer: no response, no write
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 4'(WAIT_STATES)) begin
               state_d = ST_RESP;
               cnt_d   = '0;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Register next-state: byte-lane writes, W1C source bits, hardware set has priority
   always_comb begin
      wr_ok = commit & pwrite & ~addr_err;

      src_d = src_q | hw_intr_i;
      if (wr_ok && sel_src) begin
         src_d = (src_q & ~(pwdata[INTR_W-1:0] & wmask[INTR_W-1:0])) | hw_intr_i;
      end

      msk_d = msk_q;
      if (wr_ok && sel_msk) begin
         msk_d = (msk_q & ~wmask[INTR_W-1:0]) | (pwdata[INTR_W-1:0] & wmask[INTR_W-1:0]);
      end

      for (int i = 0; i < NUM_REGS; i++) begin
         gp_d[i] = gp_q[i];
         if (wr_ok && sel_gp[i]) begin
            gp_d[i] = (gp_q[i] & ~wmask) | (pwdata & wmask);
         end
      end
   end

   // Response and interrupt next-state; outside RESP the response outputs rest at zero
   always_comb begin
      pready_d  = commit;
      pslverr_d = commit & addr_err;
      prdata_d  = (commit && !pwrite && !addr_err) ? rd_val : '0;
      intr_d    = |(src_q & ~msk_q);
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         intr_q    <= 1'b0;
         src_q     <= '0;
         msk_q     <= '1;
         for (int i = 0; i < NUM_REGS; i++) begin
            gp_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         intr_q    <= intr_d;
         src_q     <= src_d;
         msk_q     <= msk_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            gp_q[i] <= gp_d[i];
         end
      end
   end

   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign prdata  = prdata_q;
   assign intr_o  = intr_q;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_gp_out
      assign gp_regs_o[gi*DATA_W +: DATA_W] = gp_q[gi];
   end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: directed register-map scenarios plus random APB traffic
// scored against a byte-level model of the register map. A second instance with three
// wait states covers transfer abort and reset during a wait.
module tb_apb_regfile_slave;

   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned WS       = 2;

   logic         clk = 1'b0;
   logic         rstn;
   logic [11:0]  paddr;
   logic         psel, psel3, penable, pwrite;
   logic [31:0]  pwdata;
   logic [3:0]   pstrb;
   logic [31:0]  prdata, prdata3;
   logic         pready, pready3, pslverr, pslverr3;
   logic [7:0]   hw_intr;
   logic [7:0]   hw_intr3;
   logic [31:0]  hw_status;
   logic [255:0] gp_regs, gp_regs3;
   logic         intr, intr3;

   // Model state
   logic [31:0]  gp_m [NUM_REGS];
   logic [7:0]   src_m, msk_m;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   apb_regfile_slave #(
      .ADDR_W(12), .DATA_W(32), .NUM_REGS(NUM_REGS), .WAIT_STATES(WS), .INTR_W(8)
   ) u_dut (
      .clk(clk), .rstn(rstn), .paddr(paddr), .psel(psel), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata),
      .pready(pready), .pslverr(pslverr), .hw_intr_i(hw_intr),
      .hw_status_i(hw_status), .gp_regs_o(gp_regs), .intr_o(intr)
   );

   apb_regfile_slave #(
      .ADDR_W(12), .DATA_W(32), .NUM_REGS(NUM_REGS), .WAIT_STATES(3), .INTR_W(8)
   ) u_dut3 (
      .clk(clk), .rstn(rstn), .paddr(paddr), .psel(psel3), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3),
      .pready(pready3), .pslverr(pslverr3), .hw_intr_i(hw_intr3),
      .hw_status_i(hw_status), .gp_regs_o(gp_regs3), .intr_o(intr3)
   );

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic model_err(input logic wr, input logic [11:0] a);
      logic mapped;
      mapped = (a == 12'h000) || (a == 12'h004) || (a == 12'h008) ||
               (a >= 12'h010 && a < 12'h010 + 4 * NUM_REGS && a[1:0] == 2'b00);
      return !mapped || (wr && a == 12'h008);
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] a);
      if (a == 12'h000) return {24'h0, src_m};
      if (a == 12'h004) return {24'h0, msk_m};
      if (a == 12'h008) return hw_status;
      return gp_m[(a - 12'h010) / 4];
   endfunction

   task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) begin
         if (s[b]) begin
            if (a == 12'h000 && b == 0) src_m = src_m & ~d[7:0];
            else if (a == 12'h004 && b == 0) msk_m = d[7:0];
            else if (a >= 12'h010) gp_m[(a - 12'h010) / 4][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_REGS; i++) gp_m[i] = '0;
      src_m = 8'h00;
      msk_m = 8'hFF;
   endtask

   function automatic logic [255:0] model_gp_flat();
      logic [255:0] f;
      for (int i = 0; i < NUM_REGS; i++) f[i*32 +: 32] = gp_m[i];
      return f;
   endfunction

   // One APB transfer on u_dut. Entered and left at #1 after a rising edge, so calls
   // chain back-to-back with the setup phase in the cycle following RESP.
   task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic er);
      int   lat;
      logic done;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      @(posedge clk); #1 penable = 1'b1;
      lat = 0; done = 1'b0; rd = '0; er = 1'b0;
      while (!done && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (pready) begin
            done = 1'b1;
            rd   = prdata;
            er   = pslverr;
         end
      end
      check_eq("pready_seen", done, 1'b1);
      if (done) check_eq("latency", lat, WS + 1);
      @(posedge clk); #1;
      check_eq("pready_one_cycle", pready, 1'b0);
      psel = 1'b0; penable = 1'b0;
   endtask

   // Transfer scored against the model; hw_intr is held for the whole transfer
   task automatic do_xfer(input string tag, input logic wr, input logic [11:0] a,
                          input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
      logic        er, exp_err;
      logic [31:0] exp_rd;
      exp_err = model_err(wr, a);
      exp_rd  = (!wr && !exp_err) ? model_read(a) : 32'h0;
      apb_xfer(wr, a, d, s, rd, er);
      check_eq({tag, "_pslverr"}, er, exp_err);
      check_eq({tag, "_prdata"}, rd, exp_rd);
      if (wr && !exp_err) model_write(a, d, s);
      src_m = src_m | hw_intr;
      check_eq({tag, "_gp_regs"}, gp_regs, model_gp_flat());
      check_eq({tag, "_intr_o"}, intr, |(src_m & ~msk_m));
   endtask

   task automatic pulse_intr(input logic [7:0] v);
      hw_intr = v;
      @(posedge clk); #1;
      hw_intr = 8'h00;
      src_m = src_m | v;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [11:0] a;
      logic        seen;
      int          r;

      psel = 0; psel3 = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
      hw_intr = '0; hw_intr3 = '0; hw_status = 32'h1234_5678; rstn = 1'b0;
      model_reset();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_prdata", prdata, 32'h0);
      check_eq("rst_pready", pready, 1'b0);
      check_eq("rst_pslverr", pslverr, 1'b0);
      check_eq("rst_intr_o", intr, 1'b0);
      check_eq("rst_gp_regs", gp_regs, 256'h0);
      @(posedge clk); #1 rstn = 1'b1;
      @(posedge clk); #1;

      // Reset values through the bus
      do_xfer("rd_msk_rst", 1'b0, 12'h004, 32'h0, 4'h0, rd);
      check_eq("msk_rst_val", rd, 32'h0000_00FF);
      do_xfer("rd_src_rst", 1'b0, 12'h000, 32'h0, 4'h0, rd);
      do_xfer("rd_gp0_rst", 1'b0, 12'h010, 32'h0, 4'h0, rd);

      // Full write with wait states, read back and check the flattened output
      do_xfer("wr_gp1", 1'b1, 12'h014, 32'hDEAD_BEEF, 4'hF, rd);
      do_xfer("rd_gp1", 1'b0, 12'h014, 32'h0, 4'h0, rd);
      check_eq("gp1_val", rd, 32'hDEAD_BEEF);
      check_eq("gp1_out", gp_regs[63:32], 32'hDEAD_BEEF);

      // Byte strobes
      do_xfer("wr_gp0_full", 1'b1, 12'h010, 32'hAAAA_AAAA, 4'hF, rd);
      do_xfer("wr_gp0_strb", 1'b1, 12'h010, 32'h1122_3344, 4'b0101, rd);
      do_xfer("rd_gp0_strb", 1'b0, 12'h010, 32'h0, 4'h0, rd);
      check_eq("gp0_strb_val", rd, 32'hAA22_AA44);
      do_xfer("wr_gp2_nostrb", 1'b1, 12'h018, 32'hFFFF_FFFF, 4'h0, rd);

      // Error responses
      do_xfer("rd_rsvd", 1'b0, 12'h00C, 32'h0, 4'h0, rd);
      do_xfer("rd_misalign", 1'b0, 12'h012, 32'h0, 4'h0, rd);
      do_xfer("wr_status", 1'b1, 12'h008, 32'hFFFF_FFFF, 4'hF, rd);
      do_xfer("wr_past_gp", 1'b1, 12'h030, 32'h5555_5555, 4'hF, rd);
      do_xfer("rd_status", 1'b0, 12'h008, 32'h0, 4'h0, rd);

      // Interrupt sequence
      pulse_intr(8'h08);
      @(posedge clk); #1;
      check_eq("intr_masked", intr, 1'b0);
      do_xfer("rd_src_set", 1'b0, 12'h000, 32'h0, 4'h0, rd);
      check_eq("src_set_val", rd, 32'h08);
      do_xfer("wr_msk_f7", 1'b1, 12'h004, 32'hF7, 4'hF, rd);
      check_eq("intr_unmasked", intr, 1'b1);
      hw_intr = 8'h08;
      do_xfer("w1c_set_wins", 1'b1, 12'h000, 32'h08, 4'hF, rd);
      hw_intr = 8'h00;
      do_xfer("rd_src_kept", 1'b0, 12'h000, 32'h0, 4'h0, rd);
      check_eq("src_kept_val", rd, 32'h08);
      do_xfer("w1c_clear", 1'b1, 12'h000, 32'h08, 4'hF, rd);
      check_eq("intr_cleared", intr, 1'b0);
      do_xfer("rd_src_clr", 1'b0, 12'h000, 32'h0, 4'h0, rd);

      // Randomized traffic
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 3) == 0) pulse_intr(8'($urandom));
         hw_status = $urandom;
         r = $urandom_range(0, 15);
         if (r <= 2) a = 12'(r * 4);
         else if (r == 3) a = 12'h00C;
         else if (r <= 11) a = 12'(16 + 4 * $urandom_range(0, NUM_REGS));
         else if (r == 12) a = 12'(16 + 4 * $urandom_range(0, NUM_REGS - 1) + $urandom_range(1, 3));
         else a = 12'($urandom);
         do_xfer("rand", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
      end

      // Abort during WAIT on the three-wait-state instance
      pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h5A5A_5A5A; pstrb = 4'hF;
      psel3 = 1'b1; penable = 1'b0;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 psel3 = 1'b0; penable = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (pready3) seen = 1'b1;
      end
      check_eq("abort_no_pready", seen, 1'b0);
      check_eq("abort_gp0", gp_regs3[31:0], 32'h0);
      @(posedge clk); #1;

      // Make the main instance's interrupt output high before the reset
      do_xfer("wr_msk_zero", 1'b1, 12'h004, 32'h0, 4'hF, rd);
      pulse_intr(8'h01);
      @(posedge clk); #1;
      check_eq("pre_rst_intr", intr, 1'b1);

      // Reset asserted while u_dut3 sits in WAIT with a write pending
      psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'hCAFE_F00D;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #3 rstn = 1'b0;
      #1;
      check_eq("mid_rst_pready3", pready3, 1'b0);
      check_eq("mid_rst_pslverr3", pslverr3, 1'b0);
      check_eq("mid_rst_prdata3", prdata3, 32'h0);
      check_eq("mid_rst_intr", intr, 1'b0);
      check_eq("mid_rst_gp_regs", gp_regs, 256'h0);
      check_eq("mid_rst_pready", pready, 1'b0);
      psel3 = 1'b0; penable = 1'b0;
      model_reset();
      @(posedge clk); #1 rstn = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check_eq("post_rst_gp3", gp_regs3, 256'h0);
      check_eq("post_rst_pready3", pready3, 1'b0);
      do_xfer("rd_msk_post", 1'b0, 12'h004, 32'h0, 4'h0, rd);
      do_xfer("rd_gp1_post", 1'b0, 12'h014, 32'h0, 4'h0, rd);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
Parametrised APB3 register-file slave: generic RW register bank, read-only status word, sticky interrupt source/mask pair with level interrupt output. Adds programmable wait states, byte strobes, write-1-to-clear interrupt bits and full PSLVERR reporting. Sits behind the APB interconnect as the control/status front end of a peripheral.

Parameters:
ADDR_W, 12, APB address width; NUM_REGS must satisfy 0x10+4*NUM_REGS <= 2**ADDR_W
DATA_W, 32, data width; multiple of 8, <= 32
NUM_REGS, 8, number of general-purpose RW registers, 1..64
WAIT_STATES, 0, extra access-phase cycles before PREADY, 0..15
INTR_W, 8, number of interrupt sources, 1..DATA_W

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
paddr  in  ADDR_W  byte address
psel  in  1  slave select
penable  in  1  access phase
pwrite  in  1  1=write, 0=read
pwdata  in  DATA_W  write data
pstrb  in  DATA_W/8  byte write strobes
prdata  out  DATA_W  read data, valid when pready=1
pready  out  1  transfer complete (registered)
pslverr  out  1  transfer error, valid when pready=1
hw_intr_i  in  INTR_W  level interrupt requests from core
hw_status_i  in  DATA_W  live status from core
gp_regs_o  out  NUM_REGS*DATA_W  GP register contents; reg i at [i*DATA_W +: DATA_W]
intr_o  out  1  registered, OR of unmasked pending interrupts

Behaviour:
- Register map:
  - 0x000 INTR_SRC: W1C, sticky, bits [INTR_W-1:0], upper bits read 0.
  - 0x004 INTR_MSK: RW, 1=masked.
  - 0x008 STATUS: RO, returns hw_status_i sampled at response.
  - 0x00C: reserved, error.
  - 0x010+4*i: GP[i], RW.
  - All other addresses: error.
- Reset values: prdata=0, pready=0, pslverr=0, intr_o=0, INTR_SRC=0, INTR_MSK=all ones, GP=0, FSM=IDLE, wait counter=0.
- FSM states:
  - IDLE: pready=0, prdata=0. On psel&penable: go to RESP if WAIT_STATES=0, else go to WAIT with cnt=1.
  - WAIT: cnt++ each cycle. Go to RESP on the cycle cnt==WAIT_STATES.
  - RESP: pready=1 for exactly one cycle, then unconditionally IDLE.
- Latency: pready rises WAIT_STATES+1 cycles after the first cycle with psel&penable high.
- On entry to RESP, in the same edge that sets pready:
  - Writes commit.
  - prdata and pslverr are loaded.
- Abort: if psel drops while in WAIT, return to IDLE. No write, no response.
- Error (pslverr=1, prdata=0, no state change) on any of:
  - unmapped or reserved address;
  - paddr[1:0]!=0;
  - write to STATUS.
- Write rules:
  - Byte lane b of GP/INTR_MSK updates only when pstrb[b]=1.
  - pstrb=0 is a legal no-op with pslverr=0.
  - INTR_SRC bit k clears when written 1 with its strobe lane set.
- Interrupt capture:
  - INTR_SRC[k] sets every cycle hw_intr_i[k]=1.
  - Simultaneous set and W1C of the same bit: set wins.
- intr_o <= |(INTR_SRC & ~INTR_MSK[INTR_W-1:0]). One cycle after a source bit or mask change.
- Reads have no side effects; INTR_SRC is not clear-on-read.
- Back-to-back transfers: a new setup phase is accepted in the cycle after RESP. No dead cycle is required beyond APB's own setup phase.
- Reset asserted mid-transfer: all state returns to reset values immediately and any pending write is dropped.

Test Plan:
1. Reset, then read 0x004, 0x000, 0x010 -> 0x000000FF (INTR_W=8), 0x0, 0x0; pslverr=0; pready one cycle each.
2. WAIT_STATES=2: write 0x014=0xDEADBEEF, pstrb=0xF -> pready 3 cycles after penable. Read back -> 0xDEADBEEF. gp_regs_o[63:32]=0xDEADBEEF.
3. pstrb=4'b0101, write 0x010=0x11223344 over 0xAAAAAAAA -> reads 0xAA22AA44.
4. Error cases:
   - Read 0x00C -> pslverr=1, prdata=0.
   - Read 0x012 -> pslverr=1, prdata=0.
   - Write 0x008 -> pslverr=1, STATUS unchanged.
   - Write past last GP -> pslverr=1, no register changes.
5. Interrupt sequence:
   - Pulse hw_intr_i[3] one cycle -> INTR_SRC=0x08, intr_o stays 0 (masked).
   - Write MSK=0xF7 -> intr_o=1 next cycle.
   - W1C 0x08 while hw_intr_i[3]=1 -> bit stays set.
   - Repeat W1C with input low -> INTR_SRC=0, intr_o=0.
6. WAIT_STATES=3: drop psel during WAIT of a write to 0x010 -> no pready, GP[0] unchanged. Assert rstn=0 mid-WAIT -> all outputs return to reset values immediately.
